// File: rtl/sort_sched_if.sv
// Requester, result and sorter-side signals of sort_sched, grouped as one bus.
// The slave modport is the scheduler; the master modport is its environment.
interface sort_sched_if #(
   parameter int max_size = 16,
   parameter int bit_size = 16
);
   logic                         req0;
   logic                         req1;
   logic [bit_size-1:0]          n0;
   logic [bit_size-1:0]          n1;
   logic [bit_size-1:0]          din0;
   logic [bit_size-1:0]          din1;
   logic                         din_valid0;
   logic                         din_valid1;
   logic                         gnt0;
   logic                         gnt1;
   logic                         din_ready;
   logic [bit_size-1:0]          dout;
   logic                         dout_valid;
   logic                         dout_last;
   logic                         dout_id;
   logic                         err;
   logic [bit_size-1:0]          s_n;
   logic [bit_size-1:0]          s_dataIn;
   logic                         s_R_I;
   logic                         s_reset;
   logic [bit_size*max_size-1:0] s_dataOut;
   logic                         s_R_O;

   modport slave (
      input  req0, req1, n0, n1, din0, din1, din_valid0, din_valid1, s_dataOut, s_R_O,
      output gnt0, gnt1, din_ready, dout, dout_valid, dout_last, dout_id, err,
             s_n, s_dataIn, s_R_I, s_reset
   );

   modport master (
      output req0, req1, n0, n1, din0, din1, din_valid0, din_valid1, s_dataOut, s_R_O,
      input  gnt0, gnt1, din_ready, dout, dout_valid, dout_last, dout_id, err,
             s_n, s_dataIn, s_R_I, s_reset
   );
endinterface

// File: rtl/sort_sched.sv
// Two-requester front end for an external parallel sorter: arbitrates jobs, streams
// elements into the sorter, then drains its descending result in ascending order.
module sort_sched #(
   parameter int max_size = 16,
   parameter int bit_size = 16
) (
   input logic         clk,
   input logic         reset,
   sort_sched_if.slave bus
);
   localparam int                  idx_w = (max_size > 1) ? $clog2(max_size) : 1;
   localparam logic [bit_size-1:0] max_n = bit_size'(max_size);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] CLR   = 3'd1;
   localparam logic [2:0] WAIT  = 3'd2;
   localparam logic [2:0] LOAD  = 3'd3;
   localparam logic [2:0] SORT  = 3'd4;
   localparam logic [2:0] DRAIN = 3'd5;
   localparam logic [2:0] ERR   = 3'd6;

   logic [2:0]                   state;
   logic [2:0]                   state_nx;
   logic                         id_reg;
   logic                         ptr;
   logic                         sorted;
   logic [bit_size-1:0]          n_reg;
   logic [bit_size-1:0]          count;
   logic [idx_w-1:0]             idx;
   logic [bit_size*max_size-1:0] res_q;
   logic [bit_size-1:0]          slice [max_size];

   logic                         any_req;
   logic                         grant_id;
   logic [bit_size-1:0]          n_sel;
   logic                         n_bad;
   logic                         sel_valid;
   logic [bit_size-1:0]          sel_din;
   logic                         load_ready;
   logic                         accept;
   logic                         last_load;

   // Slice k of the sorter result is its (k+1)-th largest element.
   for (genvar k = 0; k < max_size; k++) begin : g_slice
      assign slice[k] = res_q[k*bit_size +: bit_size];
   end

   // Round-robin only matters on a tie; a lone requester is granted directly.
   assign any_req   = bus.req0 || bus.req1;
   assign grant_id  = (bus.req0 && bus.req1) ? ptr : bus.req1;
   assign n_sel     = grant_id ? bus.n1 : bus.n0;
   assign n_bad     = (n_sel == '0) || (n_sel > max_n);

   assign sel_valid  = id_reg ? bus.din_valid1 : bus.din_valid0;
   assign sel_din    = id_reg ? bus.din1 : bus.din0;
   assign load_ready = (state == LOAD) && (count < n_reg);
   assign accept     = load_ready && sel_valid;
   assign last_load  = accept && (count == n_reg - bit_size'(1));

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (any_req) state_nx = n_bad ? ERR : CLR;
         CLR:     state_nx = WAIT;
         WAIT:    state_nx = LOAD;
         LOAD:    if (last_load) state_nx = SORT;
         SORT:    if (sorted) state_nx = DRAIN;
         DRAIN:   if (idx == '0) state_nx = IDLE;
         ERR:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         id_reg <= 1'b0;
         ptr    <= 1'b0;
         sorted <= 1'b0;
         n_reg  <= '0;
         count  <= '0;
         idx    <= '0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (any_req) begin
                  id_reg <= grant_id;
                  n_reg  <= n_sel;
                  count  <= '0;
                  sorted <= 1'b0;
               end
            end
            LOAD: if (accept) count <= count + bit_size'(1);
            SORT: begin
               // The result is registered one cycle before draining starts.
               if (bus.s_R_O) sorted <= 1'b1;
               if (sorted) idx <= idx_w'(n_reg - bit_size'(1));
            end
            DRAIN: begin
               idx <= idx - idx_w'(1);
               if (idx == '0) ptr <= ~id_reg;
            end
            ERR: ptr <= ~id_reg;
            default: ;
         endcase
      end
   end

   // NOTE: the result buffer has no reset; it is always written on s_R_O before DRAIN reads it.
   always_ff @(posedge clk) begin
      if ((state == SORT) && bus.s_R_O && !sorted) res_q <= bus.s_dataOut;
   end

   assign bus.gnt0       = (state != IDLE) && !id_reg;
   assign bus.gnt1       = (state != IDLE) && id_reg;
   assign bus.din_ready  = load_ready;
   assign bus.s_R_I      = accept;
   assign bus.s_dataIn   = (state == LOAD) ? sel_din : '0;
   assign bus.s_n        = n_reg;
   assign bus.s_reset    = !reset || (state == CLR);
   assign bus.dout       = (state == DRAIN) ? slice[idx] : '0;
   assign bus.dout_valid = (state == DRAIN);
   assign bus.dout_last  = ((state == DRAIN) && (idx == '0)) || (state == ERR);
   assign bus.dout_id    = ((state == DRAIN) || (state == ERR)) && id_reg;
   assign bus.err        = (state == ERR);
endmodule

// File: tb/tb_sort_sched.sv
// Self-checking bench for sort_sched with a behavioural external sorter and a
// queue-based reference model of the expected ascending output streams.
`timescale 1ns/1ps
module tb_sort_sched;
   localparam int MS = 16;
   localparam int BS = 16;

   typedef struct {
      bit            id;
      logic [BS-1:0] data;
      bit            last;
      int            cyc;
   } out_t;

   typedef struct {
      bit id;
      bit last;
      bit valid;
   } err_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   sort_sched_if #(.max_size(MS), .bit_size(BS)) sif ();
   sort_sched #(.max_size(MS), .bit_size(BS)) dut (.clk(clk), .reset(reset), .bus(sif));

   logic          req_d [2];
   logic [BS-1:0] n_d   [2];
   logic [BS-1:0] din_d [2];
   logic          dv_d  [2];

   assign sif.req0       = req_d[0];
   assign sif.req1       = req_d[1];
   assign sif.n0         = n_d[0];
   assign sif.n1         = n_d[1];
   assign sif.din0       = din_d[0];
   assign sif.din1       = din_d[1];
   assign sif.din_valid0 = dv_d[0];
   assign sif.din_valid1 = dv_d[1];

   logic [3*BS+7:0] out_vec;
   assign out_vec = {sif.gnt0, sif.gnt1, sif.din_ready, sif.dout, sif.dout_valid, sif.dout_last,
                     sif.dout_id, sif.err, sif.s_n, sif.s_dataIn, sif.s_R_I};

   int   tests_run = 0;
   int   tests_failed = 0;
   bit   rr_ptr = 1'b0;
   out_t exp_q[$];

   // ---------------- external sorter model ----------------
   logic [BS-1:0] sq[$];
   int            sdelay;
   bit            sdone;

   always @(posedge clk or negedge reset) begin
      logic [BS-1:0]       t[$];
      logic [BS*MS-1:0]    v;
      if (!reset) begin
         sq.delete();
         sdone = 1'b0;
         sdelay = 0;
         sif.s_R_O <= 1'b0;
         sif.s_dataOut <= '0;
      end else if (sif.s_reset) begin
         sq.delete();
         sdone = 1'b0;
         sdelay = $urandom_range(0, 3);
         sif.s_R_O <= 1'b0;
      end else begin
         if (sif.s_R_I) sq.push_back(sif.s_dataIn);
         if (sif.s_R_O) begin
            // Result is only valid with s_R_O; scramble it afterwards.
            for (int k = 0; k < MS; k++) v[k*BS +: BS] = BS'($urandom);
            sif.s_dataOut <= v;
            sif.s_R_O <= 1'b0;
         end else if (!sdone && sif.s_n != '0 && sq.size() == int'(sif.s_n)) begin
            if (sdelay > 0) sdelay--;
            else begin
               t = sq;
               t.rsort();
               v = '0;
               foreach (t[k]) v[k*BS +: BS] = t[k];
               sif.s_dataOut <= v;
               sif.s_R_O <= 1'b1;
               sdone = 1'b1;
            end
         end
      end
   end

   // ---------------- output monitor ----------------
   out_t outs[$];
   err_t errs[$];
   int   cyc = 0, sri_cnt, srst_cnt, both_gnt, rst_dout, ro_cyc;
   int   gnt_cyc[2];
   bit   ro_prev = 1'b0;

   always @(negedge clk) begin
      out_t o;
      err_t e;
      cyc++;
      if (reset) begin
         if (sif.dout_valid) begin
            o.id = sif.dout_id; o.data = sif.dout; o.last = sif.dout_last; o.cyc = cyc;
            outs.push_back(o);
         end
         if (sif.err) begin
            e.id = sif.dout_id; e.last = sif.dout_last; e.valid = sif.dout_valid;
            errs.push_back(e);
         end
         if (sif.s_R_I) sri_cnt++;
         if (sif.s_reset) srst_cnt++;
         if (sif.gnt0 && sif.gnt1) both_gnt++;
         if (sif.gnt0) gnt_cyc[0]++;
         if (sif.gnt1) gnt_cyc[1]++;
         if (sif.s_R_O && !ro_prev) ro_cyc = cyc;
      end else if (sif.dout_valid) begin
         rst_dout++;
      end
      ro_prev = sif.s_R_O;
   end

   // ---------------- helpers (stimulus and model, no checking) ----------------
   task automatic clear_mon();
      outs.delete(); errs.delete(); exp_q.delete();
      sri_cnt = 0; srst_cnt = 0; both_gnt = 0; rst_dout = 0; ro_cyc = -1;
      gnt_cyc[0] = 0; gnt_cyc[1] = 0;
   endtask

   task automatic settle();
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic gen_data(input int n, input bit all_ones, output logic [BS-1:0] q[$]);
      q.delete();
      for (int k = 0; k < n; k++) q.push_back(all_ones ? {BS{1'b1}} : BS'($urandom));
   endtask

   // Reference: a job yields its elements sorted ascending, last flag on the final one.
   function automatic void add_exp(input bit id, input logic [BS-1:0] d[$]);
      logic [BS-1:0] s[$];
      out_t          e;
      s = d;
      s.sort();
      foreach (s[k]) begin
         e.id = id; e.data = s[k]; e.last = (k == s.size() - 1); e.cyc = 0;
         exp_q.push_back(e);
      end
   endfunction

   function automatic int stream_diff(output string msg);
      msg = "";
      if (outs.size() != exp_q.size()) begin
         msg = $sformatf("count got %0d required %0d", outs.size(), exp_q.size());
         return 0;
      end
      foreach (exp_q[k])
         if (outs[k].id !== exp_q[k].id || outs[k].data !== exp_q[k].data || outs[k].last !== exp_q[k].last) begin
            msg = $sformatf("idx %0d got id=%0d data=%h last=%0d required id=%0d data=%h last=%0d", k,
                            outs[k].id, outs[k].data, outs[k].last, exp_q[k].id, exp_q[k].data, exp_q[k].last);
            return k;
         end
      return -1;
   endfunction

   task automatic drive_job(input int id, input logic [BS-1:0] n, input logic [BS-1:0] data[$],
                            input int on_c, input int off_c, input bit hold_valid, input bit noise,
                            input int stop_after);
      int idx = 0, phase = 0, budget = 3000;
      bit g, v;
      @(posedge clk); #1;
      req_d[id] = 1'b1; n_d[id] = n; dv_d[id] = 1'b0;
      forever begin
         @(posedge clk); #1;
         g = (id == 1) ? sif.gnt1 : sif.gnt0;
         if (g && sif.dout_last) begin
            req_d[id] = 1'b0; dv_d[id] = 1'b0;
            break;
         end
         if (stop_after > 0 && idx >= stop_after) begin
            dv_d[id] = 1'b0;
            break;
         end
         if (g && sif.din_ready && idx < data.size()) begin
            v = (phase % (on_c + off_c)) < on_c;
            phase++;
            din_d[id] = data[idx]; dv_d[id] = v;
            if (v) idx++;
         end else if (g) begin
            dv_d[id] = hold_valid && (idx >= data.size()); din_d[id] = BS'($urandom);
         end else if (noise) begin
            dv_d[id] = 1'($urandom_range(0, 1)); din_d[id] = BS'($urandom);
         end else begin
            dv_d[id] = 1'b0;
         end
         budget--;
         if (budget == 0) begin
            tests_run++; tests_failed++;
            $display("FAIL drive_timeout id=%0d: no dout_last seen, required job completion", id);
            req_d[id] = 1'b0; dv_d[id] = 1'b0;
            break;
         end
      end
   endtask

   task automatic pulse_reset();
      @(posedge clk); #2 reset = 1'b0;
      repeat (2) @(posedge clk);
      #2 reset = 1'b1;
      rr_ptr = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      req_d[0] = 1'b1; n_d[0] = 16'd4;
      repeat (3) @(negedge clk);
      tests_run++;
      if (out_vec !== '0) begin
         tests_failed++; $display("FAIL reset_outputs: got %h required 0", out_vec);
      end
      tests_run++;
      if (sif.s_reset !== 1'b1) begin
         tests_failed++; $display("FAIL reset_s_reset: got %b required 1", sif.s_reset);
      end
      req_d[0] = 1'b0;
      @(posedge clk); #2 reset = 1'b1;
      rr_ptr = 1'b0;
      @(negedge clk);
      tests_run++;
      if (out_vec !== '0 || sif.s_reset !== 1'b0) begin
         tests_failed++; $display("FAIL idle_after_reset: got %h/%b required 0/0", out_vec, sif.s_reset);
      end
   endtask

   task automatic test_basic();
      logic [BS-1:0] d[$];
      string         msg;
      int            r;
      @(posedge clk); #1;
      clear_mon();
      d = '{16'd9, 16'd3, 16'd7, 16'd1};
      add_exp(1'b0, d);
      fork
         drive_job(0, 16'd4, d, 1, 0, 1'b0, 1'b0, 0);
         begin
            int k = 0;
            while (sif.gnt0 !== 1'b1 && k < 20) begin @(negedge clk); k++; end
            tests_run++;
            if (k >= 20) begin
               tests_failed++; $display("FAIL basic_grant: got no gnt0 required gnt0 within 20 cycles");
            end else begin
               tests_run++;
               if ({sif.s_reset, sif.s_n} !== {1'b1, 16'd4}) begin
                  tests_failed++; $display("FAIL basic_clr: got s_reset=%b s_n=%0d required 1/4", sif.s_reset, sif.s_n);
               end
               @(negedge clk);
               tests_run++;
               if ({sif.s_reset, sif.din_ready, sif.gnt0} !== 3'b001) begin
                  tests_failed++; $display("FAIL basic_wait: got %b required 001", {sif.s_reset, sif.din_ready, sif.gnt0});
               end
               @(negedge clk);
               tests_run++;
               if ({sif.din_ready, sif.s_R_I, sif.s_dataIn} !== {2'b11, 16'd9}) begin
                  tests_failed++; $display("FAIL basic_load: got %b/%0d required 11/9", {sif.din_ready, sif.s_R_I}, sif.s_dataIn);
               end
            end
         end
      join
      settle();
      r = stream_diff(msg);
      tests_run++;
      if (r != -1) begin tests_failed++; $display("FAIL basic_stream: %s", msg); end
      tests_run++;
      if (srst_cnt !== 1) begin tests_failed++; $display("FAIL basic_s_reset_cycles: got %0d required 1", srst_cnt); end
      tests_run++;
      if (outs.size() > 0 && outs[0].cyc - ro_cyc !== 2) begin
         tests_failed++; $display("FAIL basic_latency: got %0d required 2", outs[0].cyc - ro_cyc);
      end
      tests_run++;
      if ({sif.gnt0, sif.gnt1} !== 2'b00) begin tests_failed++; $display("FAIL basic_gnt_release: got %b required 00", {sif.gnt0, sif.gnt1}); end
      rr_ptr = 1'b1;
   endtask

   task automatic test_arbitration();
      logic [BS-1:0] d0[$], d1[$];
      int            n0, n1, r;
      string         msg;
      pulse_reset();
      @(posedge clk); #1;
      clear_mon();
      n0 = $urandom_range(1, MS); n1 = $urandom_range(1, MS);
      gen_data(n0, 1'b0, d0); gen_data(n1, 1'b0, d1);
      add_exp(1'b0, d0); add_exp(1'b1, d1);
      fork
         drive_job(0, BS'(n0), d0, 1, 0, 1'b0, 1'b1, 0);
         drive_job(1, BS'(n1), d1, 1, 0, 1'b0, 1'b1, 0);
      join
      settle();
      r = stream_diff(msg);
      tests_run++;
      if (r != -1) begin tests_failed++; $display("FAIL arb_stream: %s", msg); end
      tests_run++;
      if (both_gnt !== 0) begin tests_failed++; $display("FAIL arb_gnt_onehot: got %0d overlap cycles required 0", both_gnt); end
      tests_run++;
      if (srst_cnt !== 2) begin tests_failed++; $display("FAIL arb_s_reset_cycles: got %0d required 2", srst_cnt); end
      rr_ptr = 1'b0;
   endtask

   task automatic test_error(input int bad_n);
      logic [BS-1:0] d[$];
      @(posedge clk); #1;
      clear_mon();
      d.delete();
      drive_job(1, BS'(bad_n), d, 1, 0, 1'b0, 1'b0, 0);
      settle();
      tests_run++;
      if (errs.size() !== 1) begin
         tests_failed++; $display("FAIL err_n%0d_count: got %0d err cycles required 1", bad_n, errs.size());
      end else begin
         tests_run++;
         if ({errs[0].id, errs[0].last, errs[0].valid} !== 3'b110) begin
            tests_failed++; $display("FAIL err_n%0d_fields: got id/last/valid=%b required 110", bad_n, {errs[0].id, errs[0].last, errs[0].valid});
         end
      end
      tests_run++;
      if ({outs.size(), srst_cnt, gnt_cyc[1]} !== {32'd0, 32'd0, 32'd1}) begin
         tests_failed++; $display("FAIL err_n%0d_side: got dout=%0d s_reset=%0d gnt1=%0d required 0/0/1", bad_n, outs.size(), srst_cnt, gnt_cyc[1]);
      end
      rr_ptr = 1'b0;
   endtask

   task automatic test_gaps();
      logic [BS-1:0] d[$];
      string         msg;
      int            r;
      @(posedge clk); #1;
      clear_mon();
      gen_data(3, 1'b0, d);
      add_exp(1'b0, d);
      drive_job(0, 16'd3, d, 1, 2, 1'b1, 1'b0, 0);
      settle();
      tests_run++;
      if (sri_cnt !== 3) begin tests_failed++; $display("FAIL gaps_s_R_I: got %0d pulses required 3", sri_cnt); end
      r = stream_diff(msg);
      tests_run++;
      if (r != -1) begin tests_failed++; $display("FAIL gaps_stream: %s", msg); end
      rr_ptr = 1'b1;
   endtask

   task automatic test_full();
      logic [BS-1:0] d[$];
      string         msg;
      int            r;
      for (int pass = 0; pass < 2; pass++) begin
         @(posedge clk); #1;
         clear_mon();
         gen_data(MS, pass == 0, d);
         add_exp(1'b0, d);
         drive_job(0, BS'(MS), d, 1, 0, 1'b0, 1'b0, 0);
         settle();
         r = stream_diff(msg);
         tests_run++;
         if (r != -1) begin tests_failed++; $display("FAIL full%0d_stream: %s", pass, msg); end
         tests_run++;
         if (outs.size() > 0 && outs[0].cyc - ro_cyc !== 2) begin
            tests_failed++; $display("FAIL full%0d_latency: got %0d required 2", pass, outs[0].cyc - ro_cyc);
         end
      end
      rr_ptr = 1'b1;
   endtask

   task automatic test_reset_mid();
      logic [BS-1:0] d[$];
      string         msg;
      int            r;
      @(posedge clk); #1;
      clear_mon();
      gen_data(4, 1'b0, d);
      drive_job(0, 16'd4, d, 1, 0, 1'b0, 1'b0, 2);
      #2 reset = 1'b0;
      #1;
      tests_run++;
      if (out_vec !== '0 || sif.s_reset !== 1'b1) begin
         tests_failed++; $display("FAIL midreset_async: got %h/%b required 0/1", out_vec, sif.s_reset);
      end
      req_d[0] = 1'b0; dv_d[0] = 1'b0;
      repeat (2) @(posedge clk);
      #2 reset = 1'b1;
      rr_ptr = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      tests_run++;
      if (outs.size() !== 0 || rst_dout !== 0) begin
         tests_failed++; $display("FAIL midreset_no_dout: got %0d/%0d outputs required 0", outs.size(), rst_dout);
      end
      clear_mon();
      gen_data(4, 1'b0, d);
      add_exp(1'b0, d);
      drive_job(0, 16'd4, d, 1, 0, 1'b0, 1'b0, 0);
      settle();
      r = stream_diff(msg);
      tests_run++;
      if (r != -1) begin tests_failed++; $display("FAIL midreset_new_job: %s", msg); end
      rr_ptr = 1'b1;
   endtask

   task automatic test_random();
      logic [BS-1:0] da[$], db[$];
      string         msg;
      int            r, mode, na, nb, on_c, off_c;
      bit            first, second;
      for (int it = 0; it < 10; it++) begin
         @(posedge clk); #1;
         clear_mon();
         mode = $urandom_range(0, 3);
         na = $urandom_range(1, MS); nb = $urandom_range(1, MS);
         on_c = $urandom_range(1, 2); off_c = $urandom_range(0, 2);
         gen_data(na, 1'b0, da); gen_data(nb, 1'b0, db);
         first = 1'($urandom_range(0, 1));
         if (mode == 0) begin
            add_exp(first, da);
            drive_job(int'(first), BS'(na), da, on_c, off_c, 1'b0, 1'b0, 0);
            rr_ptr = ~first;
         end else if (mode == 3) begin
            da.delete();
            na = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MS + 1, 200);
            drive_job(int'(first), BS'(na), da, 1, 0, 1'b0, 1'b0, 0);
            rr_ptr = ~first;
         end else begin
            first = rr_ptr; second = ~rr_ptr;
            add_exp(first, da); add_exp(second, db);
            fork
               drive_job(int'(first), BS'(na), da, on_c, off_c, 1'b0, 1'b1, 0);
               drive_job(int'(second), BS'(nb), db, on_c, off_c, 1'b0, 1'b1, 0);
            join
            rr_ptr = first;
         end
         settle();
         r = stream_diff(msg);
         tests_run++;
         if (r != -1) begin tests_failed++; $display("FAIL rand%0d_mode%0d_stream: %s", it, mode, msg); end
         tests_run++;
         if (errs.size() !== ((mode == 3) ? 1 : 0) || both_gnt !== 0) begin
            tests_failed++; $display("FAIL rand%0d_mode%0d_side: got err=%0d overlap=%0d required %0d/0", it, mode, errs.size(), both_gnt, (mode == 3) ? 1 : 0);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         req_d[i] = 1'b0; n_d[i] = '0; din_d[i] = '0; dv_d[i] = 1'b0;
      end
      clear_mon();
      test_reset();
      test_basic();
      test_arbitration();
      test_error(0);
      test_error(MS + 1);
      test_gaps();
      test_full();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got simulation still running required completion before 1 ms");
      $fatal(1, "watchdog expired");
   end
endmodule
